// File: rtl/attendance_session_ctrl.sv
// attendance_session_ctrl
// Sequencing stage wrapped around the fingerprint attendance checker.
// It accepts one scanner event at a time and walks it through the states
// IDLE -> ARM -> PRESENT -> SAMPLE -> REPORT. During the scan it presents
// OnTime / attendFlag / Fingerprint to the checker in a safe order. It then
// samples AttendanceAccepted and reports one registered result.
//
// Optional feature macro: LATE_LOG_EN (adds the late_count output).
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   day_start       pulse: open a new session (clears timer and records)
//   scan_valid/id   scanner event, accepted when scan_ready is high
//   scan_ready      controller idle and able to take a scan
//   fp_out          checker Fingerprint
//   on_time         checker OnTime (live in IDLE, frozen during a scan)
//   attend_flag     checker attendFlag
//   accepted_in     checker AttendanceAccepted
//   result_valid    one-cycle result strobe (REPORT)
//   result_ok/dup   result of the last scan, held until the next REPORT
//   attended        bit k-1 set once employee k has attended
//   attend_count    number of distinct employees attended this session
//   late_count      (LATE_LOG_EN only) saturating count of late scans
module attendance_session_ctrl #(
   parameter int TICKS_PER_MIN = 4,
   parameter int WINDOW_MIN    = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       day_start,
   input  logic       scan_valid,
   input  logic [2:0] scan_id,
   output logic       scan_ready,
   output logic [2:0] fp_out,
   output logic       on_time,
   output logic       attend_flag,
   input  logic       accepted_in,
   output logic       result_valid,
   output logic       result_ok,
   output logic       result_dup,
   output logic [2:0] attended,
   output logic [1:0] attend_count
`ifdef LATE_LOG_EN
   ,
   output logic [3:0] late_count
`endif
);

   localparam int TW = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;

   typedef enum logic [2:0] {IDLE, ARM, PRESENT, SAMPLE, REPORT} state_t;

   state_t        state_reg, state_next;
   logic          session_reg;
   logic [TW-1:0] tick_reg;
   logic [5:0]    minute_reg;
   logic [2:0]    id_reg;
   logic          flag_reg;
   logic          frozen_reg;
   logic          ok_reg;
   logic          dup_reg;
   logic [2:0]    attended_reg;
   logic [1:0]    count_reg;
   logic [2:0]    id_onehot;
   logic [2:0]    scan_onehot;
   logic          id_valid;
   logic          live_on_time;

   // One-hot decode of the employee codes 1..3; any other code decodes to 0,
   // so "valid" is simply the OR of the decode.
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_dec
         assign id_onehot[gi]   = (id_reg == 3'(gi + 1));
         assign scan_onehot[gi] = (scan_id == 3'(gi + 1));
      end
   endgenerate

   assign id_valid     = |id_onehot;
   assign live_on_time = session_reg && (minute_reg < 6'(WINDOW_MIN));

   always_comb begin
      state_next   = state_reg;
      scan_ready   = 1'b0;
      fp_out       = 3'b000;
      // OnTime follows the timer only while idle; during a scan the value
      // captured at acceptance is held so a minute boundary cannot disturb it.
      on_time      = (state_reg == IDLE) ? live_on_time : frozen_reg;
      attend_flag  = flag_reg;
      result_valid = 1'b0;
      case (state_reg)
         IDLE: begin
            scan_ready = !rst && !day_start;
            if (scan_valid && scan_ready) state_next = ARM;
         end
         ARM:     state_next = PRESENT;
         PRESENT: begin
            fp_out     = id_reg;
            state_next = SAMPLE;
         end
         SAMPLE: begin
            fp_out     = id_reg;
            state_next = REPORT;
         end
         REPORT: begin
            result_valid = 1'b1;
            state_next   = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

`ifdef LATE_LOG_EN
   logic [3:0] late_reg;
   assign late_count = late_reg;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         session_reg  <= 1'b0;
         tick_reg     <= '0;
         minute_reg   <= '0;
         id_reg       <= '0;
         flag_reg     <= 1'b0;
         frozen_reg   <= 1'b0;
         ok_reg       <= 1'b0;
         dup_reg      <= 1'b0;
         attended_reg <= '0;
         count_reg    <= '0;
`ifdef LATE_LOG_EN
         late_reg     <= '0;
`endif
      end else if (day_start) begin
         // A new session aborts any scan in flight without a result.
         state_reg    <= IDLE;
         session_reg  <= 1'b1;
         tick_reg     <= '0;
         minute_reg   <= '0;
         flag_reg     <= 1'b0;
         attended_reg <= '0;
         count_reg    <= '0;
`ifdef LATE_LOG_EN
         late_reg     <= '0;
`endif
      end else begin
         state_reg <= state_next;
         if (session_reg) begin
            if (tick_reg == TW'(TICKS_PER_MIN - 1)) begin
               tick_reg <= '0;
               if (minute_reg != 6'd63) minute_reg <= minute_reg + 6'd1;
            end else begin
               tick_reg <= tick_reg + TW'(1);
            end
         end
         case (state_reg)
            IDLE: begin
               if (scan_valid) begin
                  id_reg     <= scan_id;
                  flag_reg   <= |(scan_onehot & attended_reg);
                  frozen_reg <= live_on_time;
               end
            end
            SAMPLE: begin
               ok_reg  <= accepted_in;
               dup_reg <= flag_reg;
            end
            REPORT: begin
               flag_reg <= 1'b0;
               // The count tracks distinct employees, so it only moves when
               // a bit is newly set.
               if (ok_reg && id_valid && !(|(attended_reg & id_onehot))) begin
                  attended_reg <= attended_reg | id_onehot;
                  count_reg    <= count_reg + 2'd1;
               end
`ifdef LATE_LOG_EN
               if (id_valid && !dup_reg && !frozen_reg && session_reg &&
                   late_reg != 4'd15)
                  late_reg <= late_reg + 4'd1;
`endif
            end
            default: ;
         endcase
      end
   end

   assign result_ok    = ok_reg;
   assign result_dup   = dup_reg;
   assign attended     = attended_reg;
   assign attend_count = count_reg;

endmodule

// File: doc/attendance_session_ctrl.md
# attendance_session_ctrl

Sequencing stage wrapped around the fingerprint attendance checker. It accepts scanner events through a valid/ready handshake and tracks the daily on-time window with a tick/minute timer. It keeps a per-employee "already attended" record and drives the checker's `OnTime`, `attendFlag` and `Fingerprint` inputs in a safe order. It then samples the checker's `AttendanceAccepted` and reports one registered result per scan.

## Interface
- `TICKS_PER_MIN`, default 4: clock cycles per minute (small for simulation).
- `WINDOW_MIN`, default 15: session minutes counted as on time, range 1..63.
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `day_start`, in, 1: one-cycle pulse that opens a new session.
- `scan_valid`, in, 1: scanner event present.
- `scan_id`, in, 3: scanned fingerprint code.
- `scan_ready`, out, 1: controller can accept a scan.
- `fp_out`, out, 3: drives checker `Fingerprint`.
- `on_time`, out, 1: drives checker `OnTime`.
- `attend_flag`, out, 1: drives checker `attendFlag`.
- `accepted_in`, in, 1: from checker `AttendanceAccepted`.
- `result_valid`, out, 1: one-cycle result strobe.
- `result_ok`, out, 1: attendance accepted.
- `result_dup`, out, 1: the employee had already attended.
- `attended`, out, 3: bit k-1 is set once employee k (k = 1..3) has attended.
- `attend_count`, out, 2: number of distinct employees attended this session.

## Operation
- Valid employee codes are 3'b001, 3'b010 and 3'b011. Every other code is invalid.
- **Timer**
  - The tick counter runs 0..TICKS_PER_MIN-1.
  - Each wrap increments a 6-bit minute counter, which saturates at 63.
  - Both counters run only while a session is open.
- **Session**
  - `day_start` sets the session open, clears the tick counter, minute counter, `attended` and `attend_count`, and returns the FSM to IDLE. Any in-flight scan is aborted with no result.
  - No session is open after reset.
- `on_time` = session open AND minute < WINDOW_MIN. It is held constant in every state except IDLE.
- **FSM** (one cycle per state except IDLE):
  - IDLE: `scan_ready` = 1 when `!rst && !day_start`. On `scan_valid && scan_ready`, latch `scan_id` and go to ARM.
  - ARM: drive `attend_flag` from the latched id (the `attended` bit for a valid code, 0 for an invalid code); `fp_out` = 3'b000. Go to PRESENT.
  - PRESENT: `fp_out` = latched id. Go to SAMPLE.
  - SAMPLE: register `accepted_in` and the `attend_flag` value. Go to REPORT.
  - REPORT:
    - Pulse `result_valid`, with `result_ok` = the sampled accept and `result_dup` = the sampled `attend_flag`.
    - If `result_ok` and the code is valid: set its `attended` bit and increment `attend_count`.
    - Go to IDLE.
- `fp_out` returns to 3'b000 in IDLE. This guarantees a `Fingerprint` change on every presentation, including repeated scans of the same id.
- `result_ok` and `result_dup` hold their values until the next REPORT. `result_valid` is high only during REPORT.

## Timing
- **Reset values:** state IDLE, session closed, counters 0, `fp_out` 3'b000, and `scan_ready`, `on_time`, `attend_flag`, `result_valid`, `result_ok`, `result_dup`, `attended` and `attend_count` all 0.
- **Latency:** a scan accepted at edge T produces `result_valid` high in cycle T+4. Throughput is one scan per 5 cycles.
- **Window:** `on_time` falls in the cycle after the minute counter reaches WINDOW_MIN, i.e. TICKS_PER_MIN×WINDOW_MIN cycles after `day_start`.
- **Minute boundary mid-scan:** `on_time` is frozen from ARM to REPORT. A minute boundary inside a scan does not change the checker inputs for that scan.
- **`day_start` with `scan_valid` in IDLE:** `day_start` wins and the scan is not accepted.
- **`rst` mid-scan:** all state and outputs return to reset values on the next edge and no result is produced.
- **`attend_count`:** cannot exceed 3, because each `attended` bit sets once per session.

## Configuration
- `LATE_LOG_EN`
  - **Defined:** adds output `late_count` (out, 4). It increments at REPORT when the scan is late: code valid, not already attended, and `on_time` = 0 while the session is open. It saturates at 15 and is cleared by `rst` or `day_start`.
  - **Undefined:** the port and its logic are absent. All other behaviour is identical.

## Test plan
- **Reset:** hold `rst` for 2 cycles → all outputs 0 and `scan_ready` = 0. After release, `scan_ready` = 1.
- **On-time scan:** `day_start`, then scan 3'b010 at cycle 5 → `fp_out` sequence 000, 010, 010, 000; `result_valid` at cycle 9 with ok = 1, dup = 0; `attended` = 3'b010, `attend_count` = 1.
- **Duplicate scan:** rescan 3'b010 → `attend_flag` = 1 from ARM; result ok = 0, dup = 1; `attend_count` stays 1.
- **Invalid code:** scan 3'b111 → ok = 0, dup = 0; `attended` is unchanged.
- **Late scan** (defaults): wait 61 cycles after `day_start`, then scan 3'b001 → `on_time` = 0, ok = 0. With `LATE_LOG_EN`, `late_count` = 1.
- **`day_start` mid-scan:** assert `day_start` during PRESENT → no `result_valid`; `attended` = 0, `attend_count` = 0; FSM is in IDLE on the next cycle.
